// File: rtl/centroid_arb.sv
// rtl/centroid_arb.sv - centroid engine start-window generator and result arbiter (optional drop counter: CENTROID_DROP_CNT_EN)
module centroid_arb #(
    parameter int NCH       = 2,
    parameter int DEPTH     = 2,
    parameter int BASE      = 50,
    parameter int STRIDE    = 288,
    parameter int CH_OFFSET = 144,
    parameter int WIN_LEN   = 178,
    parameter int LINE_MAX  = 863
) (
    input  logic               clk160M,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic [9:0]         cnt_r,
    input  logic [NCH-1:0]     ap_done,
    output logic [NCH-1:0]     ap_rst_n,
    output logic [NCH-1:0]     ap_start,
    input  logic [NCH-1:0]     en_in,
    input  logic [124*NCH-1:0] res_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_ch,
    output logic [123:0]       out_res,
    output logic [NCH-1:0]     ovf_flag,
    input  logic               ovf_clr
`ifdef CENTROID_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam int RW   = 124;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NWIN = LINE_MAX / STRIDE + 2;

    logic [NCH-1:0] win_hit;
    logic [RW-1:0]  mem [NCH][DEPTH];
    logic [PW-1:0]  wr_ptr [NCH];
    logic [PW-1:0]  rd_ptr [NCH];
    logic [CW-1:0]  count [NCH];
    logic [NCH-1:0] full;
    logic [NCH-1:0] nonempty;
    logic [NCH-1:0] push;
    logic [NCH-1:0] drop;
    logic [NCH-1:0] pop;
    logic           load;
    logic           found;
    logic [2:0]     sel_ch;
    logic [RW-1:0]  sel_res;
    logic [2:0]     last_grant;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1)
            return '0;
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ap_rst_n = {NCH{rst_n}} & ~ap_done;

    // Window membership per channel; int arithmetic so window ends never wrap
    always_comb begin
        int s_lo;
        int s_hi;
        int cnt_i;
        win_hit = '0;
        s_lo    = 0;
        s_hi    = 0;
        cnt_i   = int'(cnt_r);
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < NWIN; k++) begin
                s_lo = BASE + c * CH_OFFSET + k * STRIDE;
                s_hi = s_lo + WIN_LEN - 1;
                if (s_hi <= LINE_MAX && cnt_i >= s_lo && cnt_i <= s_hi)
                    win_hit[c] = 1'b1;
            end
        end
    end

    // Registered engine start, gated by the frame qualifier
    always_ff @(posedge clk160M or negedge rst_n) begin
        if (!rst_n)
            ap_start <= '0;
        else
            ap_start <= vsync ? win_hit : '0;
    end

    // FIFO status and round-robin pick of the next output source
    always_comb begin
        int idx;
        load    = !out_valid || out_ready;
        found   = 1'b0;
        sel_ch  = '0;
        sel_res = '0;
        idx     = 0;
        full    = '0;
        nonempty = '0;
        for (int c = 0; c < NCH; c++) begin
            full[c]     = (count[c] == CW'(DEPTH));
            nonempty[c] = (count[c] != '0);
        end
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last_grant) + i) % NCH;
            if (!found && nonempty[idx]) begin
                found  = 1'b1;
                sel_ch = 3'(idx);
            end
        end
        pop  = '0;
        push = '0;
        drop = '0;
        for (int c = 0; c < NCH; c++) begin
            pop[c] = load && found && (sel_ch == 3'(c));
            if (pop[c])
                sel_res = mem[c][rd_ptr[c]];
            push[c] = en_in[c] && (!full[c] || pop[c]);
            drop[c] = en_in[c] && full[c] && !pop[c];
        end
    end

    // FIFO storage; contents need no reset since counts gate visibility
    always_ff @(posedge clk160M) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c])
                mem[c][wr_ptr[c]] <= res_in[c*RW +: RW];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flags
    always_ff @(posedge clk160M or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            ovf_flag <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c])
                    wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                if (pop[c])
                    rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                if (push[c] && !pop[c])
                    count[c] <= count[c] + 1'b1;
                else if (!push[c] && pop[c])
                    count[c] <= count[c] - 1'b1;
                if (drop[c])
                    ovf_flag[c] <= 1'b1;
                else if (ovf_clr)
                    ovf_flag[c] <= 1'b0;
            end
        end
    end

    // Output holding register; reloads when empty or on a transfer
    always_ff @(posedge clk160M or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_res    <= '0;
            last_grant <= 3'(NCH - 1);
        end else if (load) begin
            if (found) begin
                out_valid  <= 1'b1;
                out_ch     <= sel_ch;
                out_res    <= sel_res;
                last_grant <= sel_ch;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

`ifdef CENTROID_DROP_CNT_EN
    logic [16:0] drop_sum;

    // Sum of drops this cycle on top of the (possibly cleared) running total
    always_comb begin
        drop_sum = ovf_clr ? 17'd0 : {1'b0, drop_cnt};
        for (int c = 0; c < NCH; c++)
            drop_sum = drop_sum + 17'(drop[c]);
    end

    // Saturating drop counter
    always_ff @(posedge clk160M or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else
            drop_cnt <= (drop_sum > 17'd65535) ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_centroid_arb.sv
// tb/tb_centroid_arb.sv - directed self-checking bench for centroid_arb
module tb_centroid_arb;

    logic         clk160M = 1'b0;
    logic         rst_n;
    logic         vsync;
    logic [9:0]   cnt_r;
    logic [1:0]   ap_done;
    logic [1:0]   ap_rst_n;
    logic [1:0]   ap_start;
    logic [1:0]   en_in;
    logic [123:0] r0, r1;
    logic [247:0] res_in;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_ch;
    logic [123:0] out_res;
    logic [1:0]   ovf_flag;
    logic         ovf_clr;
`ifdef CENTROID_DROP_CNT_EN
    logic [15:0]  drop_cnt;
`endif

    int vec = 0;
    int miscmp = 0;

    assign res_in = {r1, r0};

    always #5 clk160M = ~clk160M;

    centroid_arb #(.NCH(2), .DEPTH(2)) dut (
        .clk160M   (clk160M),
        .rst_n     (rst_n),
        .vsync     (vsync),
        .cnt_r     (cnt_r),
        .ap_done   (ap_done),
        .ap_rst_n  (ap_rst_n),
        .ap_start  (ap_start),
        .en_in     (en_in),
        .res_in    (res_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_res   (out_res),
        .ovf_flag  (ovf_flag),
        .ovf_clr   (ovf_clr)
`ifdef CENTROID_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic fail(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        miscmp++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk160M);
        #1;
    endtask

    function automatic logic exp0(input int n);
        return (n >= 50 && n <= 227) || (n >= 338 && n <= 515) || (n >= 626 && n <= 803);
    endfunction

    function automatic logic exp1(input int n);
        return (n >= 194 && n <= 371) || (n >= 482 && n <= 659);
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_start;
        rst_n = 1'b0; vsync = 1'b0; cnt_r = '0; ap_done = '0; en_in = '0;
        r0 = '0; r1 = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        vec++; if (out_valid !== 1'b0) fail("rst_out_valid", 128'(out_valid), 128'(1'b0));
        vec++; if (ap_start !== 2'b00) fail("rst_ap_start", 128'(ap_start), 128'(2'b00));
        vec++; if (ovf_flag !== 2'b00) fail("rst_ovf_flag", 128'(ovf_flag), 128'(2'b00));
        vec++; if (out_ch !== 3'd0) fail("rst_out_ch", 128'(out_ch), 128'(3'd0));
        vec++; if (out_res !== 124'd0) fail("rst_out_res", 128'(out_res), 128'(124'd0));
        vec++; if (ap_rst_n !== 2'b00) fail("rst_ap_rst_n", 128'(ap_rst_n), 128'(2'b00));
        rst_n = 1'b1;
        step();

        ap_done = 2'b10; #1;
        vec++; if (ap_rst_n !== 2'b01) fail("ap_rst_n_done1", 128'(ap_rst_n), 128'(2'b01));
        ap_done = 2'b00; #1;
        vec++; if (ap_rst_n !== 2'b11) fail("ap_rst_n_idle", 128'(ap_rst_n), 128'(2'b11));

        vsync = 1'b1;
        for (int n = 0; n < 864; n++) begin
            cnt_r = 10'(n);
            step();
            exp_start = {exp1(n), exp0(n)};
            vec++;
            if (ap_start !== exp_start) fail("ap_start_sweep", 128'(ap_start), 128'(exp_start));
        end
        vsync = 1'b0; cnt_r = 10'd200;
        step();
        vec++; if (ap_start !== 2'b00) fail("ap_start_novsync", 128'(ap_start), 128'(2'b00));

        out_ready = 1'b1;
        r0 = 124'hA0; r1 = 124'hB0; en_in = 2'b11;
        step();
        en_in = 2'b00;
        step();
        vec++; if (out_valid !== 1'b1) fail("dual_v0", 128'(out_valid), 128'(1'b1));
        vec++; if (out_ch !== 3'd0) fail("dual_ch0", 128'(out_ch), 128'(3'd0));
        vec++; if (out_res !== 124'hA0) fail("dual_res0", 128'(out_res), 128'(124'hA0));
        step();
        vec++; if (out_ch !== 3'd1) fail("dual_ch1", 128'(out_ch), 128'(3'd1));
        vec++; if (out_res !== 124'hB0) fail("dual_res1", 128'(out_res), 128'(124'hB0));
        step();
        vec++; if (out_valid !== 1'b0) fail("dual_empty", 128'(out_valid), 128'(1'b0));

        out_ready = 1'b0;
        r1 = 124'hCC; en_in = 2'b10;
        step();
        r0 = 124'hC1; en_in = 2'b01;
        step();
        r0 = 124'hC2;
        step();
        r0 = 124'hC3;
        step();
        en_in = 2'b00;
        vec++; if (ovf_flag !== 2'b01) fail("ovf_flag_set", 128'(ovf_flag), 128'(2'b01));
`ifdef CENTROID_DROP_CNT_EN
        vec++; if (drop_cnt !== 16'd1) fail("drop_cnt_one", 128'(drop_cnt), 128'(16'd1));
`endif
        vec++; if (out_res !== 124'hCC) fail("ovf_hold_res", 128'(out_res), 128'(124'hCC));
        step();
        vec++; if (out_valid !== 1'b1) fail("stall_valid", 128'(out_valid), 128'(1'b1));
        vec++; if (out_ch !== 3'd1) fail("stall_ch", 128'(out_ch), 128'(3'd1));
        vec++; if (out_res !== 124'hCC) fail("stall_res", 128'(out_res), 128'(124'hCC));
        out_ready = 1'b1;
        step();
        vec++; if (out_ch !== 3'd0) fail("ovf_first_ch", 128'(out_ch), 128'(3'd0));
        vec++; if (out_res !== 124'hC1) fail("ovf_first_res", 128'(out_res), 128'(124'hC1));
        step();
        vec++; if (out_res !== 124'hC2) fail("ovf_second_res", 128'(out_res), 128'(124'hC2));
        step();
        vec++; if (out_valid !== 1'b0) fail("ovf_drained", 128'(out_valid), 128'(1'b0));

        out_ready = 1'b0;
        r0 = 124'hD1; en_in = 2'b01; step();
        r0 = 124'hD2; step();
        r0 = 124'hD3; step();
        r0 = 124'hD4; ovf_clr = 1'b1; step();
        en_in = 2'b00;
        vec++; if (ovf_flag !== 2'b01) fail("ovf_clr_race", 128'(ovf_flag), 128'(2'b01));
`ifdef CENTROID_DROP_CNT_EN
        vec++; if (drop_cnt !== 16'd1) fail("drop_cnt_clr_race", 128'(drop_cnt), 128'(16'd1));
`endif
        step();
        ovf_clr = 1'b0;
        vec++; if (ovf_flag !== 2'b00) fail("ovf_cleared", 128'(ovf_flag), 128'(2'b00));
`ifdef CENTROID_DROP_CNT_EN
        vec++; if (drop_cnt !== 16'd0) fail("drop_cnt_cleared", 128'(drop_cnt), 128'(16'd0));
`endif

        r0 = 124'hF0; r1 = 124'hF1; en_in = 2'b11; step();
        en_in = 2'b00;
        rst_n = 1'b0; #1;
        vec++; if (out_valid !== 1'b0) fail("async_rst_valid", 128'(out_valid), 128'(1'b0));
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(); step();
        vec++; if (out_valid !== 1'b0) fail("post_rst_empty", 128'(out_valid), 128'(1'b0));
        r1 = 124'hE1; en_in = 2'b10; step();
        en_in = 2'b00; step();
        vec++; if (out_ch !== 3'd1) fail("post_rst_ch", 128'(out_ch), 128'(3'd1));
        vec++; if (out_res !== 124'hE1) fail("post_rst_res", 128'(out_res), 128'(124'hE1));
        step();
        vec++; if (out_valid !== 1'b0) fail("post_rst_drained", 128'(out_valid), 128'(1'b0));

        r0 = 124'h100; r1 = 124'h200; en_in = 2'b11; step();
        r0 = 124'h101; r1 = 124'h201; step();
        en_in = 2'b00;
        vec++; if (out_ch !== 3'd0) fail("alt0_ch", 128'(out_ch), 128'(3'd0));
        vec++; if (out_res !== 124'h100) fail("alt0_res", 128'(out_res), 128'(124'h100));
        step();
        vec++; if (out_res !== 124'h200) fail("alt1_res", 128'(out_res), 128'(124'h200));
        step();
        vec++; if (out_res !== 124'h101) fail("alt2_res", 128'(out_res), 128'(124'h101));
        step();
        vec++; if (out_ch !== 3'd1) fail("alt3_ch", 128'(out_ch), 128'(3'd1));
        vec++; if (out_res !== 124'h201) fail("alt3_res", 128'(out_res), 128'(124'h201));
        step();
        vec++; if (out_valid !== 1'b0) fail("alt_drained", 128'(out_valid), 128'(1'b0));

        out_ready = 1'b0;
        r0 = 124'h104; r1 = 124'h204; en_in = 2'b11; step();
        r0 = 124'h105; r1 = 124'h205; step();
        en_in = 2'b00;
        vec++; if (out_res !== 124'h104) fail("tog_load", 128'(out_res), 128'(124'h104));
        step();
        vec++; if (out_res !== 124'h104) fail("tog_hold0", 128'(out_res), 128'(124'h104));
        out_ready = 1'b1; step();
        vec++; if (out_res !== 124'h204) fail("tog_next", 128'(out_res), 128'(124'h204));
        out_ready = 1'b0; step();
        vec++; if (out_ch !== 3'd1) fail("tog_hold1_ch", 128'(out_ch), 128'(3'd1));
        vec++; if (out_res !== 124'h204) fail("tog_hold1_res", 128'(out_res), 128'(124'h204));
        out_ready = 1'b1; step();
        vec++; if (out_res !== 124'h105) fail("tog_a5", 128'(out_res), 128'(124'h105));
        step();
        vec++; if (out_res !== 124'h205) fail("tog_b5", 128'(out_res), 128'(124'h205));
        step();
        vec++; if (out_valid !== 1'b0) fail("tog_drained", 128'(out_valid), 128'(1'b0));
        vec++; if (ovf_flag !== 2'b00) fail("final_ovf", 128'(ovf_flag), 128'(2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
